// File: rtl/decode_stage.sv
// ID stage: IF/ID register, decoder, load-use hazard stall and ID/EX register.
// Unknown opcodes are either dropped as bubbles or issued with no control set.
package decode_stage_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        aluSrc;
    logic        regDst;
    logic        branch;
    logic [1:0]  aluOp;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pcPlus4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
  } id_ex_t;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] Instruction,
  input  logic [31:0] PCPlus4,
  input  logic        IFValid,
  input  logic        Flush,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        Stall,
  output logic        EXValid,
  output logic        EXRegWrite,
  output logic        EXMemRead,
  output logic        EXMemWrite,
  output logic        EXMemToReg,
  output logic        EXALUSrc,
  output logic        EXRegDst,
  output logic        EXBranch,
  output logic [1:0]  EXALUOp,
  output logic [31:0] EXReadData1,
  output logic [31:0] EXReadData2,
  output logic [31:0] EXImm,
  output logic [31:0] EXPCPlus4,
  output logic [4:0]  EXRs,
  output logic [4:0]  EXRt,
  output logic [4:0]  EXRd,
  output logic [5:0]  EXFunct,
  output logic        IllegalOp
);

  if_id_t ifId;
  id_ex_t idEx;
  id_ex_t idExNext;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic isR, isLw, isSw, isBeq, isAddi;
  logic illegal;
  logic usesRt;
  logic bubble;

  assign op      = ifId.instr[31:26];
  assign rs      = ifId.instr[25:21];
  assign rt      = ifId.instr[20:16];
  assign isR     = (op == 6'h00);
  assign isLw    = (op == 6'h23);
  assign isSw    = (op == 6'h2B);
  assign isBeq   = (op == 6'h04);
  assign isAddi  = (op == 6'h08);
  assign illegal = !(isR | isLw | isSw | isBeq | isAddi);
  assign usesRt  = isR | isSw | isBeq;

  assign ReadRegister1 = rs;
  assign ReadRegister2 = rt;

  // rt only counts as a source for ops that actually read it
  assign Stall = !Flush && ifId.valid && idEx.valid &&
                 idEx.memRead && (idEx.rt != 5'd0) &&
                 ((idEx.rt == rs) || ((idEx.rt == rt) && usesRt));

  assign bubble = Flush || Stall || !ifId.valid ||
                  (illegal && ILLEGAL_AS_NOP);

  always_comb begin
    idExNext         = '0;
    idExNext.rd1     = ReadData1;
    idExNext.rd2     = ReadData2;
    idExNext.imm     = {{16{ifId.instr[15]}}, ifId.instr[15:0]};
    idExNext.pcPlus4 = ifId.pcPlus4;
    idExNext.rs      = rs;
    idExNext.rt      = rt;
    idExNext.rd      = ifId.instr[15:11];
    idExNext.funct   = ifId.instr[5:0];
    if (!bubble) begin
      idExNext.valid = 1'b1;
      unique case (1'b1)
        isR: begin
          idExNext.regWrite = 1'b1;
          idExNext.regDst   = 1'b1;
          idExNext.aluOp    = 2'b10;
        end
        isLw: begin
          idExNext.regWrite = 1'b1;
          idExNext.memRead  = 1'b1;
          idExNext.memToReg = 1'b1;
          idExNext.aluSrc   = 1'b1;
        end
        isSw: begin
          idExNext.memWrite = 1'b1;
          idExNext.aluSrc   = 1'b1;
        end
        isBeq: begin
          idExNext.branch = 1'b1;
          idExNext.aluOp  = 2'b01;
        end
        isAddi: begin
          idExNext.regWrite = 1'b1;
          idExNext.aluSrc   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ifId <= '0;
    end else if (Flush) begin
      ifId.valid <= 1'b0;
    end else if (!Stall) begin
      ifId.instr   <= Instruction;
      ifId.pcPlus4 <= PCPlus4;
      ifId.valid   <= IFValid;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      idEx      <= '0;
      IllegalOp <= 1'b0;
    end else begin
      idEx      <= idExNext;
      IllegalOp <= ifId.valid && !Flush && !Stall && illegal;
    end
  end

  assign EXValid     = idEx.valid;
  assign EXRegWrite  = idEx.regWrite;
  assign EXMemRead   = idEx.memRead;
  assign EXMemWrite  = idEx.memWrite;
  assign EXMemToReg  = idEx.memToReg;
  assign EXALUSrc    = idEx.aluSrc;
  assign EXRegDst    = idEx.regDst;
  assign EXBranch    = idEx.branch;
  assign EXALUOp     = idEx.aluOp;
  assign EXReadData1 = idEx.rd1;
  assign EXReadData2 = idEx.rd2;
  assign EXImm       = idEx.imm;
  assign EXPCPlus4   = idEx.pcPlus4;
  assign EXRs        = idEx.rs;
  assign EXRt        = idEx.rt;
  assign EXRd        = idEx.rd;
  assign EXFunct     = idEx.funct;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: ILLEGAL_AS_NOP, default 1; when 1 an unknown opcode is issued as a bubble, when 0 it issues with all control outputs 0 and only IllegalOp is flagged.
REQ-002 Port: Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: Instruction  input  32  fetched instruction word.
REQ-005 Port: PCPlus4  input  32  fetch PC + 4, carried alongside the instruction.
REQ-006 Port: IFValid  input  1  Instruction and PCPlus4 are valid this cycle.
REQ-007 Port: Flush  input  1  branch-taken kill from EX; squashes both the IF/ID and the ID/EX contents.
REQ-008 Port: ReadRegister1, ReadRegister2  output  5 each  rs and rt of the IF/ID instruction, driven to the register file.
REQ-009 Port: ReadData1, ReadData2  input  32 each  register-file read data; the register file updates these on the falling edge of Clk.
REQ-010 Port: Stall  output  1  hold request to fetch (PC and IF source).
REQ-011 Port: EXValid, EXRegWrite, EXMemRead, EXMemWrite, EXMemToReg, EXALUSrc, EXRegDst, EXBranch  output  1 each  ID/EX valid bit and control bits.
REQ-012 Port: EXALUOp  output  2  00 add, 01 subtract, 10 use funct.
REQ-013 Port: EXReadData1, EXReadData2, EXImm, EXPCPlus4  output  32 each  ID/EX data fields.
REQ-014 Port: EXRs, EXRt, EXRd  output  5 each  ID/EX register fields.
REQ-015 Port: EXFunct  output  6  ID/EX funct field.
REQ-016 Port: IllegalOp  output  1  registered; high for one cycle when an unknown opcode leaves ID.

Function
REQ-017 The IF/ID register SHALL hold Instruction, PCPlus4 and a valid bit IDValid.
REQ-018 On each rising edge, IF/ID SHALL be updated in priority order: Flush -> IDValid=0; else Stall -> hold all fields; else load Instruction, PCPlus4 and IFValid.
REQ-019 ReadRegister1 SHALL be IF/ID Instruction[25:21] and ReadRegister2 SHALL be IF/ID Instruction[20:16], both combinational from the IF/ID register.
REQ-020 ReadData1 and ReadData2 SHALL be captured into ID/EX at the rising edge that ends the ID cycle; decode-to-EX latency is exactly 1 cycle per instruction.
REQ-021 Decoding SHALL be:
  - op 0x00 (R-type): RegWrite=1, RegDst=1, ALUOp=10
  - op 0x23 (lw): RegWrite=1, MemRead=1, MemToReg=1, ALUSrc=1, ALUOp=00
  - op 0x2B (sw): MemWrite=1, ALUSrc=1, ALUOp=00
  - op 0x04 (beq): Branch=1, ALUOp=01
  - op 0x08 (addi): RegWrite=1, ALUSrc=1, ALUOp=00
  - any other op: illegal.
REQ-022 EXImm SHALL be Instruction[15:0] sign-extended to 32 bits.
REQ-023 EXRs, EXRt, EXRd and EXFunct SHALL be Instruction[25:21], [20:16], [15:11] and [5:0] respectively.
REQ-024 Stall SHALL be combinational and asserted when all of the following hold:
  - IDValid=1, EXValid=1, EXMemRead=1 and EXRt != 0;
  - EXRt equals the ID rs, or EXRt equals the ID rt and the ID op is R-type, sw or beq.
REQ-025 Stall SHALL be forced to 0 while Flush=1.
REQ-026 On each rising edge, ID/EX SHALL load a bubble (EXValid=0 and every control bit and EXALUOp = 0) when Flush=1, Stall=1 or IDValid=0, and the decoded instruction otherwise.
REQ-027 Data fields SHALL be don't-care in a bubble but SHALL still be loaded deterministically.
REQ-028 Flush SHALL take precedence over Stall when both are high in the same cycle.
REQ-029 A single load-use hazard SHALL cost exactly one stall cycle: the bubble clears the hazard the next cycle.
REQ-030 Register $0 as a destination SHALL NOT cause a stall.
REQ-031 Back-to-back valid instructions with no hazard SHALL issue one per cycle with no gaps.
REQ-032 No bypass from writeback is required; same-cycle write-then-read ordering is provided by the register file's rising-edge write and falling-edge read.

Reset
REQ-033 While Rst_n=0, IDValid, EXValid, all EX control bits, EXALUOp, IllegalOp and Stall SHALL be 0, and all 32-bit and 5-bit EX fields SHALL be 0, independent of Clk.
REQ-034 The first IF/ID load SHALL occur at the first rising edge after Rst_n rises.
REQ-035 Reset asserted mid-stall SHALL discard the stalled instruction; it is not replayed.

Verification
REQ-036 Instruction=0x02115020 (add $t2,$s0,$s1) with $s0=$s1=2 -> two edges later: EXValid=1, EXReadData1=2, EXReadData2=2, EXRd=10, EXFunct=0x20, EXRegWrite=1, EXRegDst=1, EXALUOp=10.
REQ-037 Instruction=0xAE08FFFC (sw $t0,-4($s0)) -> EXImm=0xFFFFFFFC, EXMemWrite=1, EXALUSrc=1, EXRegWrite=0, EXRs=16, EXRt=8.
REQ-038 0x8D110004 (lw $s1,4($t0)) then 0x02115020 -> Stall=1 for exactly one cycle, one bubble with EXValid=0, then the add issues with EXRs=16 and EXRt=17.
REQ-039 Flush=1 in the same cycle as a load-use Stall -> Stall=0, and EXValid=0 and IDValid=0 on the next edge.
REQ-040 Opcode 0x3F with ILLEGAL_AS_NOP=1 -> IllegalOp pulses for 1 cycle and EXValid=0; Rst_n pulsed low mid-stream -> all EX outputs are 0 before the next Clk edge.
